// File: rtl/scaled_frame_writer.sv
// Writes the downscaled pixel stream into a ping-pong pair of BRAM frame banks,
// keeping even input lines only and swapping banks when a frame is complete.
module scaled_frame_writer #(
    parameter int IN_W   = 320,
    parameter int IN_H   = 480,
    parameter int DATA_W = 12,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              scaler_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              frame_done,
    output logic              sync_err
);

    localparam int XW = (IN_W > 1) ? $clog2(IN_W) : 1;
    localparam int YW = (IN_H > 1) ? $clog2(IN_H) : 1;

    localparam logic [XW-1:0]     X_LAST    = XW'(IN_W - 1);
    localparam logic [YW-1:0]     Y_LAST    = YW'(IN_H - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IN_W * IN_H / 2 - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [ADDR_W-1:0] waddr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            x          <= '0;
            y          <= '0;
            waddr      <= '0;
            scaler_en  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b1;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    scaler_en <= 1'b0;
                    if (frame_start) begin
                        state     <= S_RUN;
                        scaler_en <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                        waddr     <= '0;
                    end
                end
                S_RUN: begin
                    // A frame_start here means the camera resynced: drop the
                    // in-flight pixel and restart the frame in the same bank.
                    if (frame_start) begin
                        sync_err <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                        waddr    <= '0;
                    end else if (in_valid) begin
                        if (!y[0]) begin
                            wr_en   <= 1'b1;
                            wr_addr <= waddr;
                            wr_data <= in_data;
                            waddr   <= (waddr == ADDR_LAST) ? '0 : waddr + 1'b1;
                        end
                        if (x == X_LAST) begin
                            x <= '0;
                            if (y == Y_LAST) begin
                                y          <= '0;
                                waddr      <= '0;
                                state      <= S_DONE;
                                scaler_en  <= 1'b0;
                                frame_done <= 1'b1;
                                wr_bank    <= ~wr_bank;
                                rd_bank    <= wr_bank;
                            end else begin
                                y <= y + 1'b1;
                            end
                        end else begin
                            x <= x + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (frame_start) begin
                        state     <= S_RUN;
                        scaler_en <= 1'b1;
                        x         <= '0;
                        y         <= '0;
                        waddr     <= '0;
                    end else begin
                        state     <= S_IDLE;
                        scaler_en <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    scaler_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scaled_frame_writer.sv
// Randomised and directed bench for scaled_frame_writer on a 4x4 input frame,
// checked cycle by cycle against a pixel-index reference model.
module tb_scaled_frame_writer;

    localparam int IN_W   = 4;
    localparam int IN_H   = 4;
    localparam int DATA_W = 12;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_start = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              scaler_en;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_bank;
    logic              rd_bank;
    logic              frame_done;
    logic              sync_err;

    scaled_frame_writer #(
        .IN_W  (IN_W),
        .IN_H  (IN_H),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .scaler_en  (scaler_en),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_bank    (wr_bank),
        .rd_bank    (rd_bank),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int wcount   = 0;

    // Reference model: tracks the index of the next pixel within the frame and
    // derives line, column and address from it arithmetically.
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    bit m_bank   = 1'b0;
    int m_n      = 0;
    bit e_wr_en, e_done, e_err, e_scaler;
    int e_addr, e_data;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelStep(input bit r, input bit fs, input bit iv, input int d);
        int xx, yy;
        e_wr_en = 1'b0;
        e_done  = 1'b0;
        e_err   = 1'b0;
        if (r) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_bank   = 1'b0;
            m_n      = 0;
            e_addr   = 0;
            e_data   = 0;
        end else if (m_active) begin
            if (fs) begin
                e_err = 1'b1;
                m_n   = 0;
            end else if (iv) begin
                xx = m_n % IN_W;
                yy = m_n / IN_W;
                if (yy % 2 == 0) begin
                    e_wr_en = 1'b1;
                    e_addr  = (yy / 2) * IN_W + xx;
                    e_data  = d;
                end
                m_n++;
                if (m_n == IN_W * IN_H) begin
                    e_done   = 1'b1;
                    m_bank   = !m_bank;
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_n      = 0;
                end
            end
        end else if (m_done) begin
            m_done = 1'b0;
            if (fs) begin
                m_active = 1'b1;
                m_n      = 0;
            end
        end else if (fs) begin
            m_active = 1'b1;
            m_n      = 0;
        end
        e_scaler = m_active;
    endtask

    task automatic applyStimulus(input bit r, input bit fs, input bit iv, input int d);
        rst         = r;
        frame_start = fs;
        in_valid    = iv;
        in_data     = DATA_W'(d);
        @(posedge clk);
        modelStep(r, fs, iv, d);
        #1;
        checkOutput("wr_en", 32'(wr_en), 32'(e_wr_en));
        checkOutput("scaler_en", 32'(scaler_en), 32'(e_scaler));
        checkOutput("frame_done", 32'(frame_done), 32'(e_done));
        checkOutput("sync_err", 32'(sync_err), 32'(e_err));
        checkOutput("wr_bank", 32'(wr_bank), 32'(m_bank));
        checkOutput("rd_bank", 32'(rd_bank), 32'(!m_bank));
        if (e_wr_en) begin
            checkOutput("wr_addr", 32'(wr_addr), 32'(e_addr));
            checkOutput("wr_data", 32'(wr_data), 32'(e_data));
        end
        if (wr_en === 1'b1) wcount++;
    endtask

    task automatic runFrame(input bit gaps);
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < IN_W * IN_H; i++) begin
            applyStimulus(0, 0, 1, i);
            if (gaps && i != IN_W * IN_H - 1) begin
                applyStimulus(0, 0, 0, 12'hFFF);
                applyStimulus(0, 0, 0, 12'hFFF);
            end
        end
    endtask

    initial begin
        bit bank_before;
        bit fs, iv, r;

        // Reset held three cycles, then released
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 0);
        checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
        applyStimulus(0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0);

        // Basic frame
        wcount = 0;
        runFrame(0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s2_writes", 32'(wcount), 32'd8);
        checkOutput("s2_bank", 32'(wr_bank), 32'd1);
        applyStimulus(0, 0, 0, 0);

        // Pixels before any frame_start are ignored
        wcount = 0;
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 12'h0AA);
        checkOutput("s3_no_write", 32'(wcount), 32'd0);
        runFrame(0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s3_bank", 32'(wr_bank), 32'd0);

        // Mid-frame resync
        bank_before = wr_bank;
        applyStimulus(0, 1, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 1, i);
        applyStimulus(0, 1, 1, 12'h055);
        checkOutput("s4_sync_err", 32'(sync_err), 32'd1);
        applyStimulus(0, 0, 1, 12'h100);
        checkOutput("s4_addr0", 32'(wr_addr), 32'd0);
        checkOutput("s4_data", 32'(wr_data), 32'h100);
        checkOutput("s4_bank", 32'(wr_bank), 32'(bank_before));
        for (int i = 1; i < IN_W * IN_H; i++) applyStimulus(0, 0, 1, i + 12'h200);
        applyStimulus(0, 0, 0, 0);

        // Gapped frame
        wcount = 0;
        runFrame(1);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s5_writes", 32'(wcount), 32'd8);

        // Back-to-back frames with frame_start on the DONE cycle
        bank_before = wr_bank;
        runFrame(0);
        runFrame(0);
        applyStimulus(0, 0, 0, 0);
        checkOutput("s6_bank", 32'(wr_bank), 32'(bank_before));

        // Randomised traffic with occasional resyncs and resets
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 999) == 0);
            fs = m_active ? ($urandom_range(0, 149) == 0) : ($urandom_range(0, 7) == 0);
            iv = ($urandom_range(0, 9) < 7);
            applyStimulus(r, fs, iv, int'($urandom_range(0, 4095)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
